// File: rtl/punc_hs_core.sv
// punc_hs_core: multicycle LC3-subset core with a req/ack memory handshake.
// Control and datapath share one state machine. The memory request and its
// address, write-enable and write data are decoded from registered state, so
// they stay stable for as long as an access waits for its acknowledge.
module punc_hs_core #(
   parameter int unsigned ADDR_W   = 16,
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int unsigned CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_ack,
   output logic              halted,
   output logic [CNT_W-1:0]  retired,
   input  logic [2:0]        rf_debug_addr,
   output logic [15:0]       rf_debug_data,
   output logic [15:0]       pc_debug_data
);

   typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StHalt} state_e;

   localparam logic [3:0] OpBr  = 4'b0000;
   localparam logic [3:0] OpAdd = 4'b0001;
   localparam logic [3:0] OpLd  = 4'b0010;
   localparam logic [3:0] OpSt  = 4'b0011;
   localparam logic [3:0] OpAnd = 4'b0101;
   localparam logic [3:0] OpNot = 4'b1001;
   localparam logic [3:0] OpJmp = 4'b1100;
   localparam logic [3:0] OpLea = 4'b1110;
   localparam logic [3:0] OpHlt = 4'b1111;

   state_e           state_q;
   logic [15:0]      pc_q;
   logic [15:0]      ir_q;
   logic [15:0]      rf_q [8];
   logic [2:0]       cc_q;      // {N, Z, P}
   logic [CNT_W-1:0] retired_q;

   logic [3:0]  opcode;
   logic [2:0]  dr;
   logic [2:0]  sr1;
   logic [2:0]  sr2;
   logic [15:0] imm5_sext;
   logic [15:0] off9_sext;
   logic [15:0] src1;
   logic [15:0] src2;
   logic [15:0] ea;
   logic [15:0] alu_res;
   logic        br_taken;

   assign opcode    = ir_q[15:12];
   assign dr        = ir_q[11:9];
   assign sr1       = ir_q[8:6];
   assign sr2       = ir_q[2:0];
   assign imm5_sext = {{11{ir_q[4]}}, ir_q[4:0]};
   assign off9_sext = {{7{ir_q[8]}}, ir_q[8:0]};
   assign src1      = rf_q[sr1];
   assign src2      = ir_q[5] ? imm5_sext : rf_q[sr2];
   assign ea        = pc_q + off9_sext;
   assign br_taken  = (ir_q[11] & cc_q[2]) | (ir_q[10] & cc_q[1]) | (ir_q[9] & cc_q[0]);

   function automatic logic [2:0] cc_of(input logic [15:0] v);
      if (v[15]) begin
         return 3'b100;
      end else if (v == 16'h0000) begin
         return 3'b010;
      end else begin
         return 3'b001;
      end
   endfunction

   // Result written back to R[DR] by the register-writing EXEC opcodes.
   always_comb begin
      alu_res = 16'h0000;
      case (opcode)
         OpAdd:   alu_res = src1 + src2;
         OpAnd:   alu_res = src1 & src2;
         OpNot:   alu_res = ~src1;
         OpLea:   alu_res = ea;
         default: alu_res = 16'h0000;
      endcase
   end

   // Memory port decoded from state; rst gates the request off immediately.
   always_comb begin
      mem_req   = !rst && ((state_q == StFetch) || (state_q == StMem));
      mem_we    = mem_req && (state_q == StMem) && (opcode == OpSt);
      mem_addr  = (state_q == StMem) ? ea[ADDR_W-1:0] : pc_q[ADDR_W-1:0];
      mem_wdata = rf_q[dr];
   end

   assign halted        = (state_q == StHalt);
   assign retired       = retired_q;
   assign rf_debug_data = rf_q[rf_debug_addr];
   assign pc_debug_data = pc_q;

   // Core state machine: fetch, decode, execute, memory access, halt.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StFetch;
         pc_q      <= RESET_PC;
         ir_q      <= 16'h0000;
         cc_q      <= 3'b010;
         retired_q <= '0;
         for (int i = 0; i < 8; i++) begin
            rf_q[i] <= 16'h0000;
         end
      end else begin
         case (state_q)
            StFetch: begin
               if (mem_ack) begin
                  ir_q    <= mem_rdata;
                  pc_q    <= pc_q + 16'd1;
                  state_q <= StDecode;
               end
            end
            StDecode: begin
               state_q <= StExec;
            end
            StExec: begin
               state_q   <= StFetch;
               retired_q <= retired_q + CNT_W'(1);
               case (opcode)
                  OpAdd, OpAnd, OpNot, OpLea: begin
                     rf_q[dr] <= alu_res;
                     cc_q     <= cc_of(alu_res);
                  end
                  OpBr: begin
                     if (br_taken) begin
                        pc_q <= ea;
                     end
                  end
                  OpJmp: begin
                     pc_q <= src1;
                  end
                  OpLd, OpSt: begin
                     // Retires when the memory access completes instead.
                     state_q   <= StMem;
                     retired_q <= retired_q;
                  end
                  OpHlt: begin
                     state_q <= StHalt;
                  end
                  default: begin
                  end
               endcase
            end
            StMem: begin
               if (mem_ack) begin
                  if (opcode == OpLd) begin
                     rf_q[dr] <= mem_rdata;
                     cc_q     <= cc_of(mem_rdata);
                  end
                  retired_q <= retired_q + CNT_W'(1);
                  state_q   <= StFetch;
               end
            end
            StHalt: begin
               state_q <= StHalt;
            end
            default: begin
               state_q <= StFetch;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_punc_hs_core.sv
// Directed bench for punc_hs_core: programs are loaded into a behavioural
// memory with a configurable number of wait cycles per access.
module tb_punc_hs_core;

   logic        clk;
   logic        rst;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ack;
   logic        halted;
   logic [31:0] retired;
   logic [2:0]  rf_debug_addr;
   logic [15:0] rf_debug_data;
   logic [15:0] pc_debug_data;

   punc_hs_core #(
      .ADDR_W  (16),
      .RESET_PC(16'h0000),
      .CNT_W   (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ack      (mem_ack),
      .halted       (halted),
      .retired      (retired),
      .rf_debug_addr(rf_debug_addr),
      .rf_debug_data(rf_debug_data),
      .pc_debug_data(pc_debug_data)
   );

   int total = 0;
   int bad   = 0;

   logic [15:0] mem [65536];
   int          waits    = 0;
   bit          manual   = 0;
   logic        man_ack  = 0;
   logic [15:0] man_rdata = 16'h0000;
   int          unstable = 0;
   int          wr_cnt   = 0;
   logic [15:0] wr_addr  = 16'h0000;
   logic [15:0] wr_data  = 16'h0000;

   typedef struct {
      logic [2:0]  sel;
      logic [15:0] exp;
   } rf_vec_t;

   rf_vec_t vec [4];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: acts 1 time unit after each falling edge.
   initial begin
      int          wcnt;
      bit          pend;
      logic [15:0] p_addr;
      logic [15:0] p_wd;
      logic        p_we;
      wcnt      = 0;
      pend      = 0;
      p_addr    = '0;
      p_wd      = '0;
      p_we      = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = 16'h0000;
      forever begin
         @(negedge clk);
         #1;
         if (manual) begin
            mem_ack   = man_ack;
            mem_rdata = man_rdata;
            wcnt      = 0;
            pend      = 0;
         end else begin
            mem_ack = 1'b0;
            if (rst || !mem_req) begin
               wcnt = 0;
               pend = 0;
            end else begin
               if (pend && (mem_addr != p_addr || mem_we != p_we ||
                            (mem_we && mem_wdata != p_wd))) begin
                  unstable++;
               end
               if (wcnt == waits) begin
                  mem_ack   = 1'b1;
                  mem_rdata = mem[mem_addr];
                  if (mem_we) begin
                     mem[mem_addr] = mem_wdata;
                     wr_cnt++;
                     wr_addr = mem_addr;
                     wr_data = mem_wdata;
                  end
                  wcnt = 0;
                  pend = 0;
               end else begin
                  wcnt++;
                  pend   = 1;
                  p_addr = mem_addr;
                  p_we   = mem_we;
                  p_wd   = mem_wdata;
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 65536; i++) begin
         mem[i] = 16'h0000;
      end
      unstable = 0;
      wr_cnt   = 0;
   endtask

   // Two clock edges of reset; returns at the falling edge where rst drops.
   task automatic reset_dut(input string tag);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk({tag, " rst req"}, {31'd0, mem_req}, 32'd0);
      chk({tag, " rst halted"}, {31'd0, halted}, 32'd0);
      chk({tag, " rst pc"}, {16'd0, pc_debug_data}, 32'h0000);
      chk({tag, " rst retired"}, retired, 32'd0);
      rst = 1'b0;
   endtask

   task automatic run_to_halt(output int cycles);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!halted && n < 400);
      cycles = n + 1;
   endtask

   task automatic wait_retired(input string name, input int target);
      int n;
      n = 0;
      while (retired != target && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(name, retired, target);
   endtask

   task automatic check_regs(input string tag, input int cnt);
      for (int i = 0; i < cnt; i++) begin
         rf_debug_addr = vec[i].sel;
         #1;
         chk($sformatf("%s R%0d", tag, vec[i].sel), {16'd0, rf_debug_data}, {16'd0, vec[i].exp});
      end
   endtask

   task automatic load_prog1();
      clear_mem();
      mem[0] = 16'h1265;  // ADD R1,R1,#5
      mem[1] = 16'h5464;  // AND R2,R1,#4
      mem[2] = 16'h967F;  // NOT R3,R1
      mem[3] = 16'hF025;  // HALT
   endtask

   initial begin
      int cyc;
      rst           = 1'b1;
      rf_debug_addr = 3'd0;
      vec[0] = '{3'd1, 16'h0005};
      vec[1] = '{3'd2, 16'h0004};
      vec[2] = '{3'd3, 16'hFFFA};
      vec[3] = '{3'd0, 16'h0000};

      // Zero-wait ALU program.
      waits = 0;
      load_prog1();
      reset_dut("t1");
      #2;
      chk("t1 req after release", {31'd0, mem_req}, 32'd1);
      run_to_halt(cyc);
      chk("t1 cycles", cyc, 13);
      chk("t1 halted", {31'd0, halted}, 32'd1);
      chk("t1 retired", retired, 32'd4);
      chk("t1 cc", {29'd0, dut.cc_q}, 32'b100);
      check_regs("t1", 4);

      // Same program with three wait cycles on every access.
      waits = 3;
      load_prog1();
      reset_dut("t2");
      run_to_halt(cyc);
      chk("t2 cycles", cyc, 25);
      chk("t2 retired", retired, 32'd4);
      chk("t2 cc", {29'd0, dut.cc_q}, 32'b100);
      chk("t2 stable", unstable, 0);
      check_regs("t2", 4);

      // Load, store, load back through memory.
      waits = 0;
      clear_mem();
      mem[0] = 16'h2205;  // LD R1, PC+5 -> 0006
      mem[1] = 16'h3202;  // ST R1, PC+2 -> 0004
      mem[2] = 16'h2801;  // LD R4, PC+1 -> 0004
      mem[3] = 16'hF025;  // HALT
      mem[6] = 16'hABCD;
      reset_dut("t3");
      run_to_halt(cyc);
      chk("t3 cycles", cyc, 16);
      chk("t3 write count", wr_cnt, 1);
      chk("t3 write addr", {16'd0, wr_addr}, 32'h0004);
      chk("t3 write data", {16'd0, wr_data}, 32'hABCD);
      chk("t3 cc", {29'd0, dut.cc_q}, 32'b100);
      chk("t3 retired", retired, 32'd4);
      vec[0] = '{3'd4, 16'hABCD};
      vec[1] = '{3'd1, 16'hABCD};
      check_regs("t3", 2);

      // Branches, JMP, illegal opcode and PC wrap.
      clear_mem();
      mem[16'h0000] = 16'h5020;  // AND R0,R0,#0 -> Z
      mem[16'h0001] = 16'h0401;  // BRz +1 (taken)
      mem[16'h0002] = 16'hF025;  // HALT (skipped)
      mem[16'h0003] = 16'h0A01;  // BRnp +1 (not taken)
      mem[16'h0004] = 16'hEAFB;  // LEA R5 -> 0100
      mem[16'h0005] = 16'hC140;  // JMP R5
      mem[16'h0100] = 16'h8123;  // illegal -> NOP
      mem[16'h0101] = 16'h9C3F;  // NOT R6,R0 -> FFFF
      mem[16'h0102] = 16'hC180;  // JMP R6
      mem[16'hFFFF] = 16'h0806;  // BRn +6 from wrapped PC 0000
      mem[16'h0006] = 16'hF025;  // HALT
      reset_dut("t4");
      wait_retired("t4 jmp retired", 5);
      chk("t4 jmp pc", {16'd0, pc_debug_data}, 32'h0100);
      run_to_halt(cyc);
      chk("t4 halted", {31'd0, halted}, 32'd1);
      chk("t4 final pc", {16'd0, pc_debug_data}, 32'h0007);
      chk("t4 retired", retired, 32'd10);
      vec[0] = '{3'd5, 16'h0100};
      vec[1] = '{3'd6, 16'hFFFF};
      vec[2] = '{3'd0, 16'h0000};
      check_regs("t4", 3);

      // Illegal opcode leaves registers and CC untouched.
      clear_mem();
      mem[0] = 16'h1FE3;  // ADD R7,R7,#3 -> P
      mem[1] = 16'h8FFF;  // illegal
      mem[2] = 16'hF025;  // HALT
      reset_dut("t5");
      wait_retired("t5 retire nop", 2);
      chk("t5 cc", {29'd0, dut.cc_q}, 32'b001);
      vec[0] = '{3'd7, 16'h0003};
      vec[1] = '{3'd0, 16'h0000};
      vec[2] = '{3'd4, 16'h0000};
      check_regs("t5", 3);
      run_to_halt(cyc);
      chk("t5 retired", retired, 32'd3);

      // Reset during a pending fetch; an ack arriving under reset is dropped.
      clear_mem();
      mem[0] = 16'h1265;
      mem[1] = 16'h1265;
      reset_dut("t6");
      wait_retired("t6 first retire", 1);
      man_ack   = 1'b0;
      man_rdata = 16'hF025;
      manual    = 1;
      #2;
      chk("t6 pending req", {31'd0, mem_req}, 32'd1);
      chk("t6 pending pc", {16'd0, pc_debug_data}, 32'h0001);
      @(negedge clk);
      rst = 1'b1;
      #2;
      chk("t6 req under rst", {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      man_ack = 1'b1;
      #2;
      chk("t6 req next cycle", {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      man_ack = 1'b0;
      rst     = 1'b0;
      #2;
      chk("t6 pc", {16'd0, pc_debug_data}, 32'h0000);
      chk("t6 retired", retired, 32'd0);
      chk("t6 ir", {16'd0, dut.ir_q}, 32'h0000);
      chk("t6 halted", {31'd0, halted}, 32'd0);
      chk("t6 new req", {31'd0, mem_req}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
